agc_alu_seq: RTL

Sequencer owning the ones-complement ALU units: add/sub, multiplier and divider. It accepts one operation at a time over a valid/ready request port and drives registered operands into the selected unit. It waits a per-unit latency, captures the result into response registers and presents it over a valid/ready response port. It sits between the control-pulse decoder and the combinational/megafunction ALU units.

---
 rtl/agc_alu_seq_if.sv | 26 ++
 rtl/agc_alu_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/agc_alu_seq_if.sv
// Request/response handshake bundle for the AGC ALU sequencer.
// master = control-pulse decoder side, slave = sequencer side.
interface agc_alu_seq_if #(
  parameter int NUM_BIT = 15
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [2*NUM_BIT-1:0]   req_a;
  logic [NUM_BIT-1:0]     req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [NUM_BIT-1:0]     rsp_hi;
  logic [NUM_BIT-1:0]     rsp_lo;
  logic                   rsp_uflow;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_uflow
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_uflow
  );
endinterface

// File: rtl/agc_alu_seq.sv
// Sequencer for the ones-complement add/sub, multiplier and divider units.
// Optional macro AGC_ALU_SEQ_DIVZERO_EN: short-circuits DIV by +0/-0 to an underflow response.
module agc_alu_seq #(
  parameter int NUM_BIT  = 15,
  parameter int MULT_LAT = 2,
  parameter int DIV_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  agc_alu_seq_if.slave         bus,
  output logic                 busy,
  output logic [NUM_BIT-1:0]   as_x,
  output logic [NUM_BIT-1:0]   as_y,
  output logic                 as_sub,
  input  logic [NUM_BIT-1:0]   as_sum,
  output logic [NUM_BIT-1:0]   mu_x,
  output logic [NUM_BIT-1:0]   mu_y,
  input  logic [2*NUM_BIT-1:0] mu_prod,
  input  logic                 mu_uflow,
  output logic [2*NUM_BIT-1:0] du_numer,
  output logic [NUM_BIT-1:0]   du_denom,
  input  logic [NUM_BIT-1:0]   du_quot,
  input  logic [NUM_BIT-1:0]   du_rem,
  input  logic                 du_uflow
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_DIV  = 2'b11
  } op_t;

  state_t         state, state_nxt;
  op_t            op_q;
  op_t            req_op;
  logic [CW-1:0]  cnt;
  logic           dz_q;
  logic           st_idle;
  logic           accept;
  logic           capture;
  logic           div_zero;

  assign req_op = op_t'(bus.req_op);

  // The unused encoding behaves exactly like IDLE.
  assign st_idle = (state != EXEC) && (state != HOLD);
  assign busy    = !st_idle;

  assign bus.req_ready = rst_n && (st_idle || ((state == HOLD) && bus.rsp_ready));
  assign bus.rsp_valid = (state == HOLD);
  assign accept        = bus.req_valid && bus.req_ready;
  assign capture       = (state == EXEC) && (cnt == '0);

`ifdef AGC_ALU_SEQ_DIVZERO_EN
  assign div_zero = (req_op == OP_DIV) && ((bus.req_b == '0) || (bus.req_b == '1));
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EXEC: if (cnt == '0) state_nxt = HOLD;
      HOLD: begin
        if (accept)             state_nxt = EXEC;
        else if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = accept ? EXEC : IDLE;
    endcase
  end

  // Only the selected unit's operand registers move; the others keep their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      cnt      <= '0;
      dz_q     <= 1'b0;
      as_x     <= '0;
      as_y     <= '0;
      as_sub   <= 1'b0;
      mu_x     <= '0;
      mu_y     <= '0;
      du_numer <= '0;
      du_denom <= '0;
    end else if (accept) begin
      op_q <= req_op;
      dz_q <= div_zero;
      case (req_op)
        OP_MULT: begin
          mu_x <= bus.req_a[NUM_BIT-1:0];
          mu_y <= bus.req_b;
          cnt  <= MULT_CNT;
        end
        OP_DIV: begin
          if (div_zero) begin
            cnt <= '0;
          end else begin
            du_numer <= bus.req_a;
            du_denom <= bus.req_b;
            cnt      <= DIV_CNT;
          end
        end
        default: begin
          as_x   <= bus.req_a[NUM_BIT-1:0];
          as_y   <= bus.req_b;
          as_sub <= (req_op == OP_SUB);
          cnt    <= '0;
        end
      endcase
    end else if ((state == EXEC) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Unit outputs are looked at only on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_hi    <= '0;
      bus.rsp_lo    <= '0;
      bus.rsp_uflow <= 1'b0;
    end else if (capture) begin
      case (op_q)
        OP_MULT: begin
          bus.rsp_hi    <= mu_prod[2*NUM_BIT-1:NUM_BIT];
          bus.rsp_lo    <= mu_prod[NUM_BIT-1:0];
          bus.rsp_uflow <= mu_uflow;
        end
        OP_DIV: begin
          bus.rsp_hi    <= dz_q ? '0 : du_quot;
          bus.rsp_lo    <= dz_q ? '0 : du_rem;
          bus.rsp_uflow <= dz_q | du_uflow;
        end
        default: begin
          bus.rsp_hi    <= '0;
          bus.rsp_lo    <= as_sum;
          bus.rsp_uflow <= 1'b0;
        end
      endcase
    end
  end

endmodule
